// File: rtl/mux_pkg.sv
// mux_pkg: shared select encoding and defaults for the registered one-hot mux.
package mux_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef logic [2:0] sel_t;
  localparam sel_t SEL_IP1 = 3'b001;
  localparam sel_t SEL_IP2 = 3'b010;
  localparam sel_t SEL_IP3 = 3'b100;
endpackage

// File: rtl/mux_sel_decode.sv
// mux_sel_decode: priority-resolves the select strobes and flags non-one-hot patterns.
module mux_sel_decode
  import mux_pkg::*;
(
  input  sel_t       sel,
  output logic [1:0] idx,
  output logic       valid,
  output logic       onehot_ok
);
  always_comb begin
    idx = sel[0] ? 2'd0 : sel[1] ? 2'd1 : 2'd2;
    valid = |sel;
    onehot_ok = sel == SEL_IP1 || sel == SEL_IP2 || sel == SEL_IP3;
  end
endmodule

// File: rtl/mux.sv
// mux: registered 3-input one-hot-select multiplexer with a registered select-error flag.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic [WIDTH-1:0] ip3,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel3,
  output logic [WIDTH-1:0] mux_op,
  output logic             sel_err
);
  sel_t             sel;
  logic [1:0]       idx;
  logic             valid;
  logic             onehot_ok;
  logic [WIDTH-1:0] data;
  assign sel = {sel3, sel2, sel1};
  mux_sel_decode u_dec (
    .sel       (sel),
    .idx       (idx),
    .valid     (valid),
    .onehot_ok (onehot_ok)
  );
  assign data = idx == 2'd0 ? ip1 : idx == 2'd1 ? ip2 : ip3;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mux_op  <= '0;
      sel_err <= 1'b0;
    end else begin
      if (valid) mux_op <= data;
      sel_err <= !onehot_ok;
    end
  end
  if (ASSERT_EN) begin : g_assert
    // armed blocks $past-based checks from looking back into a reset cycle
    logic armed;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) armed <= 1'b0;
      else armed <= 1'b1;
    end
    a_onehot: assert property (@(posedge clock) disable iff (reset) $onehot(sel))
      else $warning("a_onehot: select %b is not one-hot", sel);
    a_sel1: assert property (@(posedge clock) disable iff (reset)
      armed && $past(sel == SEL_IP1) |-> mux_op == $past(ip1));
    a_sel2: assert property (@(posedge clock) disable iff (reset)
      armed && $past(sel == SEL_IP2) |-> mux_op == $past(ip2));
    a_sel3: assert property (@(posedge clock) disable iff (reset)
      armed && $past(sel == SEL_IP3) |-> mux_op == $past(ip3));
    a_hold: assert property (@(posedge clock) disable iff (reset)
      armed && $past(sel == 3'b000) |-> $stable(mux_op));
    a_err: assert property (@(posedge clock) disable iff (reset)
      armed |-> sel_err == $past(!$onehot(sel)));
    a_reset: assert property (@(posedge clock) reset |-> mux_op == '0 && !sel_err);
    c_sel1: cover property (@(posedge clock) disable iff (reset) sel == SEL_IP1);
    c_sel2: cover property (@(posedge clock) disable iff (reset) sel == SEL_IP2);
    c_sel3: cover property (@(posedge clock) disable iff (reset) sel == SEL_IP3);
    c_000: cover property (@(posedge clock) disable iff (reset) sel == 3'b000);
    c_011: cover property (@(posedge clock) disable iff (reset) sel == 3'b011);
    c_101: cover property (@(posedge clock) disable iff (reset) sel == 3'b101);
    c_110: cover property (@(posedge clock) disable iff (reset) sel == 3'b110);
    c_111: cover property (@(posedge clock) disable iff (reset) sel == 3'b111);
  end
endmodule

// File: tb/tb_mux.sv
// tb_mux: directed and randomized checks of mux against a behavioural model.
module tb_mux;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ip1 = '0, ip2 = '0, ip3 = '0;
  logic       sel1 = 1'b0, sel2 = 1'b0, sel3 = 1'b0;
  logic [3:0] mux_op;
  logic       sel_err;
  logic [3:0] exp_op;
  logic       exp_err;
  int         checks = 0;
  int         errors = 0;

  mux #(.WIDTH(4), .ASSERT_EN(1'b1)) dut (
    .clock   (clock),
    .reset   (reset),
    .ip1     (ip1),
    .ip2     (ip2),
    .ip3     (ip3),
    .sel1    (sel1),
    .sel2    (sel2),
    .sel3    (sel3),
    .mux_op  (mux_op),
    .sel_err (sel_err)
  );

  always #5 clock = ~clock;

  // Model: lowest-numbered raised strobe wins, none raised holds, error unless exactly one raised.
  logic [3:0] m_ip [3];
  logic [2:0] m_sel;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_op  <= '0;
      exp_err <= 1'b0;
    end else begin
      m_ip[0] = ip1;
      m_ip[1] = ip2;
      m_ip[2] = ip3;
      m_sel = {sel3, sel2, sel1};
      for (int k = 2; k >= 0; k--)
        if (m_sel[k]) exp_op <= m_ip[k];
      exp_err <= $countones(m_sel) != 1;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model_op", mux_op, exp_op);
    check("model_err", {3'b0, sel_err}, {3'b0, exp_err});
  end

  task automatic apply(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clock);
    #1;
    {sel3, sel2, sel1} = s;
    ip1 = a;
    ip2 = b;
    ip3 = c;
  endtask

  task automatic lit(input string name, input logic [3:0] op, input logic err);
    @(negedge clock);
    check({name, "_op"}, mux_op, op);
    check({name, "_err"}, {3'b0, sel_err}, {3'b0, err});
  endtask

  logic [3:0] sweep_op [8] = '{4'h4, 4'h1, 4'h2, 4'h1, 4'h4, 4'h1, 4'h2, 4'h1};
  logic       sweep_err [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] iso;

  initial begin
    #1 reset = 1'b1;
    #2;
    check("async_reset_op", mux_op, 4'h0);
    check("async_reset_err", {3'b0, sel_err}, 4'h0);
    lit("reset", 4'h0, 1'b0);
    #1 reset = 1'b0;
    // one-hot sweep
    apply(3'b001, 4'h1, 4'h2, 4'h4); lit("sel001", 4'h1, 1'b0);
    apply(3'b010, 4'h1, 4'h2, 4'h4); lit("sel010", 4'h2, 1'b0);
    apply(3'b100, 4'h1, 4'h2, 4'h4); lit("sel100", 4'h4, 1'b0);
    // hold on no-select, unselected ip2 changes
    apply(3'b010, 4'h1, 4'h2, 4'h4); lit("pre_hold", 4'h2, 1'b0);
    apply(3'b000, 4'h1, 4'hF, 4'h4); lit("hold", 4'h2, 1'b1);
    // priority
    apply(3'b110, 4'h1, 4'h2, 4'h4); lit("prio110", 4'h2, 1'b1);
    apply(3'b111, 4'h1, 4'h2, 4'h4); lit("prio111", 4'h1, 1'b1);
    apply(3'b101, 4'h1, 4'h2, 4'h4); lit("prio101", 4'h1, 1'b1);
    // full sweep starting from a known held value of 4
    apply(3'b100, 4'h1, 4'h2, 4'h4); lit("sweep_pre", 4'h4, 1'b0);
    for (int s = 0; s < 8; s++) begin
      apply(3'(s), 4'h1, 4'h2, 4'h4);
      lit($sformatf("sweep%0d", s), sweep_op[s], sweep_err[s]);
    end
    // isolation of unselected inputs
    apply(3'b001, 4'h9, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      apply(3'b001, 4'h9, 4'($urandom), 4'($urandom));
      lit("iso", 4'h9, 1'b0);
    end
    // reset mid-operation, then immediate capture with no dead cycle
    apply(3'b100, 4'h1, 4'h2, 4'h4); lit("pre_rst", 4'h4, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_op", mux_op, 4'h0);
    check("mid_reset_err", {3'b0, sel_err}, 4'h0);
    {sel3, sel2, sel1} = 3'b010;
    ip2 = 4'hA;
    @(negedge clock);
    #1 reset = 1'b0;
    lit("post_rst", 4'hA, 1'b0);
    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      apply(3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #3 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clock);
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
